// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_pkg
//  Purpose : Shared scan-code set 2 constants, decode state encoding and the
//            key lookup helper used by the PS/2 keyboard decoder.
//  Ports   : (package - no ports)
//  Rev     : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Scan-code set 2 prefixes and the codes the game cares about
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;

    // Index of each key in the held-bit vector
    localparam logic [2:0] K_ENTER  = 3'd0;
    localparam logic [2:0] K_SPACE  = 3'd1;
    localparam logic [2:0] K_WLEFT  = 3'd2;
    localparam logic [2:0] K_WRIGHT = 3'd3;
    localparam logic [2:0] K_WUP    = 3'd4;
    localparam logic [2:0] K_FLEFT  = 3'd5;
    localparam logic [2:0] K_FRIGHT = 3'd6;
    localparam logic [2:0] K_FUP    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // Returns {hit, index}. A code seen with the wrong extended flag is a miss;
    // Enter is accepted both with and without the E0 prefix (keypad Enter).
    function automatic logic [3:0] key_lookup(input logic [7:0] code, input logic ext);
        logic [3:0] r;
        r = 4'd0;
        case (code)
            SC_ENTER: r = {1'b1, K_ENTER};
            SC_SPACE: if (!ext) r = {1'b1, K_SPACE};
            SC_A:     if (!ext) r = {1'b1, K_WLEFT};
            SC_D:     if (!ext) r = {1'b1, K_WRIGHT};
            SC_W:     if (!ext) r = {1'b1, K_WUP};
            SC_LEFT:  if (ext)  r = {1'b1, K_FLEFT};
            SC_RIGHT: if (ext)  r = {1'b1, K_FRIGHT};
            SC_UP:    if (ext)  r = {1'b1, K_FUP};
            default:  r = 4'd0;
        endcase
        return r;
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_rx
//  Purpose : PS/2 frame receiver. Synchronises the raw PS/2 clock/data pins,
//            detects falling clock edges, shifts in an 11-bit frame, checks
//            start/parity/stop and drops stale partial frames on timeout.
//  Ports   : clk, rst_n           - system clock, async active-low reset
//            ps2_clk, ps2_data    - raw asynchronous PS/2 pins
//            byte_valid           - 1-cycle strobe, byte_data holds the byte
//            byte_data[7:0]       - last good received byte
//            frame_err            - 1-cycle strobe on a rejected frame
//  Rev     : 1.0  initial release
// ============================================================================
module ps2_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      clk_sync_q;
    logic [1:0]      dat_sync_q;
    logic            clk_prev_q;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      shift_q;
    logic            par_ok_q;
    logic            byte_valid_q;
    logic [7:0]      byte_data_q;
    logic            frame_err_q;

    logic w_fall;
    logic w_data;

    assign w_fall = clk_prev_q & ~clk_sync_q[1];
    assign w_data = dat_sync_q[1];

    // Bit position and inactivity timer. Bit 0 only advances on a low start bit.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        if (w_fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd0) begin
                bit_cnt_d = w_data ? 4'd0 : 4'd1;
            end else if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_LAST) begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            clk_prev_q   <= 1'b1;
            bit_cnt_q    <= 4'd0;
            to_cnt_q     <= '0;
            shift_q      <= 8'd0;
            par_ok_q     <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk};
            dat_sync_q   <= {dat_sync_q[0], ps2_data};
            clk_prev_q   <= clk_sync_q[1];
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (w_fall) begin
                if (bit_cnt_q == 4'd0) begin
                    if (w_data) frame_err_q <= 1'b1;    // bad start bit
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_q <= {w_data, shift_q[7:1]};  // LSB first
                end else if (bit_cnt_q == 4'd9) begin
                    par_ok_q <= ^{w_data, shift_q};     // odd parity -> XOR of all 9 is 1
                end else begin
                    if (w_data && par_ok_q) begin
                        byte_valid_q <= 1'b1;
                        byte_data_q  <= shift_q;
                    end else begin
                        frame_err_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;

endmodule : ps2_rx
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_key_decoder
//  Purpose : Decodes scan-code set 2 make/break sequences from a PS/2 keyboard
//            into Enter/Space pulses and held movement-key levels.
//  Ports   : clk, rst_n                          - clock, async active-low reset
//            ps2_clk, ps2_data                   - raw PS/2 pins
//            key_enter, key_space                - 1-cycle pulse on fresh make
//            fire_left/right/up                  - arrow keys held
//            water_left/right/up                 - A/D/W keys held
//            frame_err                           - 1-cycle pulse, rejected frame
//  Rev     : 1.0  initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic key_enter,
    output logic key_space,
    output logic fire_left,
    output logic fire_right,
    output logic fire_up,
    output logic water_left,
    output logic water_right,
    output logic water_up,
    output logic frame_err
);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_err)
    );

    dec_state_t state_q;
    logic [7:0] held_q;
    logic       key_enter_q;
    logic       key_space_q;
    logic       frame_err_q;

    logic       w_prefix;   // byte is E0 or F0
    logic       w_event;    // byte completes a make or break
    logic       w_make;
    logic       w_ext;
    logic [3:0] w_lookup;
    logic       w_hit;
    logic [2:0] w_idx;

    always_comb begin
        w_prefix = (rx_data == SC_EXT) || (rx_data == SC_BRK);
        w_event  = rx_valid && !w_prefix;
        w_make   = (state_q == ST_IDLE) || (state_q == ST_EXT);
        w_ext    = (state_q == ST_EXT)  || (state_q == ST_EXT_BRK);
        w_lookup = key_lookup(rx_data, w_ext);
        w_hit    = w_event && w_lookup[3];
        w_idx    = w_lookup[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            held_q      <= 8'd0;
            key_enter_q <= 1'b0;
            key_space_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= rx_err;
            // A pulse fires only on the first make; typematic repeats see held=1.
            key_enter_q <= w_hit && w_make && (w_idx == K_ENTER) && !held_q[K_ENTER];
            key_space_q <= w_hit && w_make && (w_idx == K_SPACE) && !held_q[K_SPACE];
            if (w_hit) held_q[w_idx] <= w_make;

            if (rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == SC_EXT)      state_q <= ST_EXT;
                        else if (rx_data == SC_BRK) state_q <= ST_BRK;
                    end
                    ST_EXT: begin
                        if (rx_data == SC_BRK)      state_q <= ST_EXT_BRK;
                        else if (rx_data != SC_EXT) state_q <= ST_IDLE;
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        // Stray prefixes inside a break sequence are ignored
                        if (!w_prefix)              state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign key_enter   = key_enter_q;
    assign key_space   = key_space_q;
    assign water_left  = held_q[K_WLEFT];
    assign water_right = held_q[K_WRIGHT];
    assign water_up    = held_q[K_WUP];
    assign fire_left   = held_q[K_FLEFT];
    assign fire_right  = held_q[K_FRIGHT];
    assign fire_up     = held_q[K_FUP];
    assign frame_err   = frame_err_q;

endmodule : ps2_key_decoder
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ps2_key_decoder
//  Purpose : Directed self-checking bench for ps2_key_decoder. Drives PS/2
//            frames bit by bit and checks pulses, held levels and frame
//            errors against hand-computed values.
//  Ports   : (none)
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int HALF  = 15;   // PS/2 clock half period in clk cycles
    localparam int SETUP = 10;   // data setup before the falling edge
    localparam int GAP   = 50;   // idle time after each frame

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    logic key_enter, key_space;
    logic fire_left, fire_right, fire_up;
    logic water_left, water_right, water_up;
    logic frame_err;

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;

    // Bit k = output sampled just after clk edge k, where edge 0 is the first
    // edge that sees ps2_clk low for the stop bit. A registered output visible
    // after edge 3 is the "cycle 4" output.
    logic [15:0] h_enter, h_space, h_err;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (65000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_enter   (key_enter),
        .key_space   (key_space),
        .fire_left   (fire_left),
        .fire_right  (fire_right),
        .fire_up     (fire_up),
        .water_left  (water_left),
        .water_right (water_right),
        .water_up    (water_up),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) err_seen <= err_seen + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of an LSB-first frame; leaves the bus idle-high.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(SETUP);
            ps2_clk = 1'b0;
            if (i == 10) begin
                for (int k = 0; k < 16; k++) begin
                    @(posedge clk);
                    #1;
                    h_enter[k] = key_enter;
                    h_space[k] = key_space;
                    h_err[k]   = frame_err;
                end
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b1;
            tick(HALF);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        logic [10:0] bits;
        bits    = {stop, (~^b) ^ bad_par, b, 1'b0};
        h_enter = '0;
        h_space = '0;
        h_err   = '0;
        send_bits(bits, 11);
        tick(GAP);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        tick(5);
        checks++;
        if ({key_enter, key_space, fire_left, fire_right, fire_up,
             water_left, water_right, water_up, frame_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000000",
                     {key_enter, key_space, fire_left, fire_right, fire_up,
                      water_left, water_right, water_up, frame_err});
        end
        rst_n = 1'b1;
        tick(10);
        checks++;
        if ({key_enter, key_space, fire_left, fire_right, fire_up,
             water_left, water_right, water_up, frame_err} !== 9'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b required 000000000",
                     {key_enter, key_space, fire_left, fire_right, fire_up,
                      water_left, water_right, water_up, frame_err});
        end
    endtask

    task automatic test_enter;
        send_byte(8'h5A);
        checks++;
        if (h_enter !== 16'h0008) begin
            errors++;
            $display("FAIL enter_first_pulse: got %h required 0008", h_enter);
        end
        checks++;
        if (h_err !== 16'h0000) begin
            errors++;
            $display("FAIL enter_no_err: got %h required 0000", h_err);
        end
        send_byte(8'h5A);
        checks++;
        if (h_enter !== 16'h0000) begin
            errors++;
            $display("FAIL enter_repeat_no_pulse: got %h required 0000", h_enter);
        end
        send_byte(8'hF0);
        send_byte(8'h5A);
        checks++;
        if (h_enter !== 16'h0000) begin
            errors++;
            $display("FAIL enter_break_no_pulse: got %h required 0000", h_enter);
        end
        send_byte(8'h5A);
        checks++;
        if (h_enter !== 16'h0008) begin
            errors++;
            $display("FAIL enter_repulse: got %h required 0008", h_enter);
        end
    endtask

    task automatic test_left_arrow;
        send_byte(8'hE0);
        send_byte(8'h6B);
        checks++;
        if (fire_left !== 1'b1) begin
            errors++;
            $display("FAIL left_make: got %b required 1", fire_left);
        end
        tick(200);
        checks++;
        if (fire_left !== 1'b1) begin
            errors++;
            $display("FAIL left_held: got %b required 1", fire_left);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        checks++;
        if (fire_left !== 1'b0) begin
            errors++;
            $display("FAIL left_break: got %b required 0", fire_left);
        end
        send_byte(8'h6B);
        checks++;
        if ({fire_left, fire_right, fire_up, water_left, water_right, water_up} !== 6'b0) begin
            errors++;
            $display("FAIL left_lone_ignored: got %b required 000000",
                     {fire_left, fire_right, fire_up, water_left, water_right, water_up});
        end
    endtask

    task automatic test_two_keys;
        send_byte(8'h1C);
        send_byte(8'h23);
        checks++;
        if ({water_left, water_right} !== 2'b11) begin
            errors++;
            $display("FAIL two_keys_held: got %b required 11", {water_left, water_right});
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if ({water_left, water_right} !== 2'b01) begin
            errors++;
            $display("FAIL two_keys_one_released: got %b required 01", {water_left, water_right});
        end
        send_byte(8'hF0);
        send_byte(8'h23);
        checks++;
        if (water_right !== 1'b0) begin
            errors++;
            $display("FAIL two_keys_all_released: got %b required 0", water_right);
        end
    endtask

    task automatic test_bad_frames;
        send_frame(8'h29, 1'b1, 1'b1);
        checks++;
        if (h_err !== 16'h0008) begin
            errors++;
            $display("FAIL bad_parity_err: got %h required 0008", h_err);
        end
        checks++;
        if (h_space !== 16'h0000) begin
            errors++;
            $display("FAIL bad_parity_no_space: got %h required 0000", h_space);
        end
        send_frame(8'h29, 1'b0, 1'b0);
        checks++;
        if (h_err !== 16'h0008) begin
            errors++;
            $display("FAIL bad_stop_err: got %h required 0008", h_err);
        end
        checks++;
        if (h_space !== 16'h0000) begin
            errors++;
            $display("FAIL bad_stop_no_space: got %h required 0000", h_space);
        end
        send_byte(8'h29);
        checks++;
        if (h_space !== 16'h0008) begin
            errors++;
            $display("FAIL space_after_bad: got %h required 0008", h_space);
        end
        send_byte(8'hF0);
        send_byte(8'h29);
    endtask

    task automatic test_timeout;
        int base;
        base = err_seen;
        send_bits(11'b00000001010, 4);   // start + 3 data bits, then abandoned
        tick(70000);
        send_byte(8'h29);
        checks++;
        if (h_space !== 16'h0008) begin
            errors++;
            $display("FAIL timeout_space_pulse: got %h required 0008", h_space);
        end
        checks++;
        if (err_seen - base !== 0) begin
            errors++;
            $display("FAIL timeout_no_err: got %0d err pulses required 0", err_seen - base);
        end
        send_byte(8'hF0);
        send_byte(8'h29);
    endtask

    task automatic test_async_reset;
        send_byte(8'h1D);
        checks++;
        if (water_up !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_water_up: got %b required 1", water_up);
        end
        send_bits(11'b00000111010, 5);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({key_enter, key_space, fire_left, fire_right, fire_up,
             water_left, water_right, water_up, frame_err} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset_clear: got %b required 000000000",
                     {key_enter, key_space, fire_left, fire_right, fire_up,
                      water_left, water_right, water_up, frame_err});
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick(5);
        send_byte(8'h1D);
        checks++;
        if (water_up !== 1'b1) begin
            errors++;
            $display("FAIL reset_post_water_up: got %b required 1", water_up);
        end
        checks++;
        if (h_err !== 16'h0000) begin
            errors++;
            $display("FAIL reset_post_no_err: got %h required 0000", h_err);
        end
        // E0 prefix lost across reset: a following 74 is a plain make, not Right
        send_byte(8'hE0);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick(5);
        send_byte(8'h74);
        checks++;
        if (fire_right !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_prefix: got %b required 0", fire_right);
        end
    endtask

    initial begin
        h_enter = '0;
        h_space = '0;
        h_err   = '0;
        test_reset();
        test_enter();
        test_left_arrow();
        test_two_keys();
        test_bad_frames();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ps2_key_decoder
`default_nettype wire
